aidc_lite_code_split: RTL and testbench
=======================================

AIDC_LITE_CODE_SPLIT -- requirements
Module: aidc_lite_code_split

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 66, giving the window width presented to the decoder in bits.
REQ-002 The block SHALL have parameter BUF_SIZE, default 128, giving the bit-buffer width; BUF_SIZE SHALL be >= DATA_SIZE + 62.
REQ-003 The block SHALL have input clk, 1 bit, the clock.
REQ-004 The block SHALL have input rst_n, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have input start_i, 1 bit: begin reading a new 512-bit block.
REQ-006 The block SHALL have output rd_en_o, 1 bit: word read request to the block store.
REQ-007 The block SHALL have output rd_addr_o, 3 bits: index of the requested 64-bit word.
REQ-008 The block SHALL have input rd_data_i, 64 bits: word data, valid exactly one cycle after rd_en_o.
REQ-009 The block SHALL have output prefix_o, 2 bits: the prefix stripped from word 0.
REQ-010 The block SHALL have output valid_o, 1 bit: data_o holds decodable bits.
REQ-011 The block SHALL have output data_o, DATA_SIZE bits: next unconsumed code bits, MSB-aligned and zero-filled past the valid count.
REQ-012 The block SHALL have input ready_i, 1 bit: the decoder consumes this cycle.
REQ-013 The block SHALL have input size_i, 7 bits: bits consumed, range 1..DATA_SIZE.
REQ-014 The block SHALL have input eop_i, 1 bit: the current consume is the last code of the block.
REQ-015 The block SHALL have output done_o, 1 bit: the block has finished.
REQ-016 The block SHALL have output fail_o, 1 bit: the stream was malformed; qualified by done_o.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN and DONE; start_i SHALL be honoured only in IDLE or DONE, SHALL move the block to LOAD, and SHALL clear done_o and fail_o.
REQ-018 rd_en_o SHALL be combinational and SHALL be 1 when all of the following hold: state is LOAD or RUN; no read is pending; words_read < 8; post-consume buf_cnt <= BUF_SIZE-64.
REQ-019 rd_addr_o SHALL equal words_read, issued in order 0..7, each address exactly once per block; at most one read SHALL be outstanding.
REQ-020 The word-0 return SHALL capture prefix_o = rd_data_i[63:62], SHALL append rd_data_i[61:0], SHALL set buf_cnt to 62, and SHALL move LOAD to RUN.
REQ-021 Later returns SHALL append all 64 bits immediately below the post-consume buf_cnt valid bits; a consume and an append in the same cycle SHALL both apply (shift first, then append).
REQ-022 valid_o SHALL be 1 in RUN when buf_cnt >= DATA_SIZE, or when words_read == 8, no read is pending and buf_cnt > 0.
REQ-023 A consume is valid_o & ready_i; it SHALL shift the buffer left by size_i and SHALL decrease buf_cnt by size_i.
REQ-024 Latency SHALL be: start_i sampled at cycle T -> rd addr0 at T+1 -> addr1 at T+3 -> first valid_o at T+5.
REQ-025 A consume with eop_i and size_i <= buf_cnt SHALL move the block to DONE with done_o=1 and fail_o=0.
REQ-026 A consume with size_i > buf_cnt SHALL move the block to DONE with done_o=1 and fail_o=1, regardless of eop_i.
REQ-027 If all 8 words are read, none is pending and buf_cnt == 0 with no eop_i seen, the block SHALL move to DONE with done_o=1 and fail_o=1.
REQ-028 In DONE, rd_en_o and valid_o SHALL be 0; leftover bits SHALL be discarded, and buf_cnt and words_read SHALL be cleared on the next start_i.
REQ-029 ready_i and size_i SHALL be ignored while valid_o=0.

Reset
REQ-030 Reset SHALL force state IDLE, done_o=1, fail_o=0, valid_o=0, rd_en_o=0, prefix_o=0, buf_cnt=0, words_read=0, pending=0.
REQ-031 Reset mid-block SHALL abandon the block, and read data returned in the cycle after reset SHALL be ignored.

Configuration
REQ-032 With AIDC_LITE_SPLIT_STAT_EN defined, the block SHALL add output bits_o[9:0], the total bits consumed in the block including the 2-bit prefix, updated on entry to DONE and held until the next start_i; without the macro, the port and its counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-033 The bench SHALL cover reset: rst_n=0 for 2 cycles -> done_o=1, fail_o=0, valid_o=0, rd_en_o=0.
REQ-034 The bench SHALL cover start latency: word0=0x4000_0000_0000_0000 with start_i at T -> addr0 at T+1, addr1 at T+3, valid_o at T+5, prefix_o=2'b01, data_o[65:4]=word0[61:0].
REQ-035 The bench SHALL cover a full block: size_i=34 on every consume, eop_i on the 15th consume (2+15*34=512) -> done_o=1, fail_o=0, addresses 0..7 each read once, and bits_o=512 when the macro is defined.
REQ-036 The bench SHALL cover over-read: 10 bits remain after the final word and size_i=20 is consumed -> done_o=1, fail_o=1 on the next cycle.
REQ-037 The bench SHALL cover a missing eop: 510 bits consumed with eop_i never asserted -> done_o=1, fail_o=1.
REQ-038 The bench SHALL cover reset mid-block: rst_n=0 during RUN after 3 words -> IDLE; a following start_i re-reads from addr0 with correct prefix_o.

Source files
------------

// File: rtl/aidc_lite_code_split.sv
// Splits a 512-bit block (eight 64-bit words) into a 2-bit prefix and a left-aligned code-bit window.
// Define AIDC_LITE_SPLIT_STAT_EN to add bits_o, the total bits consumed per block.
module aidc_lite_code_split #(
    parameter int DATA_SIZE = 66,
    parameter int BUF_SIZE  = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 rd_en_o,
    output logic [2:0]           rd_addr_o,
    input  logic [63:0]          rd_data_i,
    output logic [1:0]           prefix_o,
    output logic                 valid_o,
    output logic [DATA_SIZE-1:0] data_o,
    input  logic                 ready_i,
    input  logic [6:0]           size_i,
    input  logic                 eop_i,
    output logic                 done_o,
    output logic                 fail_o
`ifdef AIDC_LITE_SPLIT_STAT_EN
    ,
    output logic [9:0]           bits_o
`endif
);
    localparam int CNT_W = $clog2(BUF_SIZE + 1);
    localparam logic [CNT_W-1:0] DATA_CNT   = CNT_W'(DATA_SIZE);
    localparam logic [CNT_W-1:0] RD_LIMIT   = CNT_W'(BUF_SIZE - 64);
    localparam logic [CNT_W-1:0] WORD_BITS  = CNT_W'(64);
    localparam logic [CNT_W-1:0] WORD0_BITS = CNT_W'(62);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [BUF_SIZE-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]    buf_cnt_q, buf_cnt_d;
    logic [3:0]          words_read_q, words_read_d;
    logic                pending_q, pending_d;
    logic [1:0]          prefix_q, prefix_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;

    logic [CNT_W-1:0]    size_cnt;
    logic [CNT_W-1:0]    post_cnt;
    logic [BUF_SIZE-1:0] shifted;
    logic [BUF_SIZE-1:0] word_ext;
    logic                consume;
    logic                over_read;
    logic                all_read;
    logic                start_ok;

    assign size_cnt  = CNT_W'(size_i);
    assign all_read  = (words_read_q == 4'd8) && !pending_q;
    assign start_ok  = start_i && (state_q == IDLE || state_q == DONE);
    assign valid_o   = (state_q == RUN) &&
                       ((buf_cnt_q >= DATA_CNT) || (all_read && buf_cnt_q != '0));
    assign consume   = valid_o && ready_i;
    assign over_read = size_cnt > buf_cnt_q;

    // Reads are throttled on the occupancy left after this cycle's consume,
    // so a word can land in the same cycle the decoder drains the buffer.
    assign post_cnt  = (consume && !over_read) ? buf_cnt_q - size_cnt : buf_cnt_q;
    assign rd_en_o   = (state_q == LOAD || state_q == RUN) && !pending_q &&
                       (words_read_q < 4'd8) && (post_cnt <= RD_LIMIT);
    assign rd_addr_o = words_read_q[2:0];

    assign shifted   = consume ? buf_q << size_i : buf_q;
    assign word_ext  = {rd_data_i, {(BUF_SIZE-64){1'b0}}};

    assign data_o    = buf_q[BUF_SIZE-1 -: DATA_SIZE];
    assign prefix_o  = prefix_q;
    assign done_o    = done_q;
    assign fail_o    = fail_q;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_cnt_d    = buf_cnt_q;
        words_read_d = rd_en_o ? words_read_q + 4'd1 : words_read_q;
        pending_d    = rd_en_o;
        prefix_d     = prefix_q;
        done_d       = done_q;
        fail_d       = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d      = LOAD;
                    buf_d        = '0;
                    buf_cnt_d    = '0;
                    words_read_d = '0;
                    pending_d    = 1'b0;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                end
            end
            LOAD: begin
                if (pending_q) begin
                    prefix_d  = rd_data_i[63:62];
                    buf_d     = {rd_data_i[61:0], {(BUF_SIZE-62){1'b0}}};
                    buf_cnt_d = WORD0_BITS;
                    state_d   = RUN;
                end
            end
            RUN: begin
                buf_d     = shifted;
                buf_cnt_d = post_cnt;
                if (pending_q) begin
                    buf_d     = shifted | (word_ext >> post_cnt);
                    buf_cnt_d = post_cnt + WORD_BITS;
                end
                if (consume && (over_read || eop_i)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    fail_d  = over_read;
                end else if (all_read && buf_cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            buf_cnt_q    <= '0;
            words_read_q <= '0;
            pending_q    <= 1'b0;
            prefix_q     <= 2'b00;
            done_q       <= 1'b1;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            words_read_q <= words_read_d;
            pending_q    <= pending_d;
            prefix_q     <= prefix_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

`ifdef AIDC_LITE_SPLIT_STAT_EN
    logic [9:0] consumed_q, consumed_d;
    logic [9:0] bits_q, bits_d;

    // The running total starts at 2 so the stripped prefix is included.
    always_comb begin
        consumed_d = consumed_q;
        bits_d     = bits_q;
        if (start_ok) begin
            consumed_d = 10'd2;
        end else if (consume) begin
            consumed_d = consumed_q + 10'(size_i);
        end
        if (state_q != DONE && state_d == DONE) begin
            bits_d = consumed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            consumed_q <= '0;
            bits_q     <= '0;
        end else begin
            consumed_q <= consumed_d;
            bits_q     <= bits_d;
        end
    end

    assign bits_o = bits_q;
`endif

endmodule

// File: tb/tb_aidc_lite_code_split.sv
// Directed bench for aidc_lite_code_split: a word-store model feeds the block and each
// scenario task compares outputs against hand-derived values and a bit-stream model.
module tb_aidc_lite_code_split;
    localparam int DATA_SIZE = 66;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start_i = 1'b0;
    logic                 rd_en_o;
    logic [2:0]           rd_addr_o;
    logic [63:0]          rd_data_i = 64'h0;
    logic [1:0]           prefix_o;
    logic                 valid_o;
    logic [DATA_SIZE-1:0] data_o;
    logic                 ready_i = 1'b0;
    logic [6:0]           size_i = 7'd0;
    logic                 eop_i = 1'b0;
    logic                 done_o;
    logic                 fail_o;
`ifdef AIDC_LITE_SPLIT_STAT_EN
    logic [9:0]           bits_o;
`endif

    int checks = 0;
    int failures = 0;

    logic [63:0]          mem [8];
    int                   read_cnt [8];
    logic [511:0]         code;
    logic                 mon_en;
    logic [2:0]           mon_addr;

    aidc_lite_code_split #(.DATA_SIZE(66), .BUF_SIZE(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .prefix_o  (prefix_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .size_i    (size_i),
        .eop_i     (eop_i),
        .done_o    (done_o),
        .fail_o    (fail_o)
`ifdef AIDC_LITE_SPLIT_STAT_EN
        ,
        .bits_o    (bits_o)
`endif
    );

    always #5 clk = ~clk;

    // Word store: a request seen at an edge is answered during the following cycle only.
    always @(posedge clk) begin
        mon_en   = rd_en_o;
        mon_addr = rd_addr_o;
        if (mon_en) read_cnt[mon_addr] = read_cnt[mon_addr] + 1;
        #1;
        rd_data_i = mon_en ? mem[mon_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic load_pattern();
        mem[0] = 64'h4A3C_5E71_9D2B_F086;
        mem[1] = 64'hC3A5_0F1E_7788_99AA;
        mem[2] = 64'h1234_5678_9ABC_DEF0;
        mem[3] = 64'hFEDC_BA98_7654_3210;
        mem[4] = 64'h0F0F_F0F0_A5A5_5A5A;
        mem[5] = 64'h1357_9BDF_2468_ACE0;
        mem[6] = 64'h8421_4218_1842_2184;
        mem[7] = 64'hDEAD_BEEF_CAFE_F00D;
    endtask

    task automatic build_code();
        logic [511:0] stream;
        stream = {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]};
        code = stream << 2;
    endtask

    task automatic clear_reads();
        for (int i = 0; i < 8; i++) read_cnt[i] = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        eop_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Leaves the bench at the falling edge one cycle after start_i was sampled.
    task automatic start_block();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_done: got %b expected 1", done_o); end
        checks++;
        if (fail_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fail: got %b expected 0", fail_o); end
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        checks++;
        if (rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en: got %b expected 0", rd_en_o); end
        checks++;
        if (prefix_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_prefix: got %b expected 00", prefix_o); end
    endtask

    task automatic test_start_latency();
        logic [65:0] exp_data;
        apply_reset();
        load_pattern();
        mem[0] = 64'h4000_0000_0000_0000;
        clear_reads();
        start_block();
        checks++;
        if ({rd_en_o, rd_addr_o} !== 4'b1_000) begin
            failures++; $display("[TB] FAIL lat_addr0: got en=%b addr=%0d expected en=1 addr=0", rd_en_o, rd_addr_o);
        end
        @(negedge clk);
        checks++;
        if (rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL lat_t2_idle: got en=%b expected 0", rd_en_o); end
        @(negedge clk);
        checks++;
        if ({rd_en_o, rd_addr_o} !== 4'b1_001) begin
            failures++; $display("[TB] FAIL lat_addr1: got en=%b addr=%0d expected en=1 addr=1", rd_en_o, rd_addr_o);
        end
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL lat_t3_valid: got %b expected 0", valid_o); end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL lat_t4_valid: got %b expected 0", valid_o); end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL lat_t5_valid: got %b expected 1", valid_o); end
        checks++;
        if (prefix_o !== 2'b01) begin failures++; $display("[TB] FAIL lat_prefix: got %b expected 01", prefix_o); end
        checks++;
        if (data_o[65:4] !== mem[0][61:0]) begin
            failures++; $display("[TB] FAIL lat_data_hi: got %h expected %h", data_o[65:4], mem[0][61:0]);
        end
        exp_data = {mem[0][61:0], mem[1][63:60]};
        checks++;
        if (data_o !== exp_data) begin failures++; $display("[TB] FAIL lat_data: got %h expected %h", data_o, exp_data); end
    endtask

    task automatic test_full_block();
        int n = 0;
        int consumed = 0;
        int cyc = 0;
        logic [511:0] tmp;
        logic [65:0]  exp_data;
        apply_reset();
        load_pattern();
        build_code();
        clear_reads();
        start_block();
        while (n < 15 && cyc < 2000) begin
            if (valid_o) begin
                tmp = code << consumed;
                exp_data = tmp[511 -: DATA_SIZE];
                checks++;
                if (data_o !== exp_data) begin
                    failures++; $display("[TB] FAIL full_data[%0d]: got %h expected %h", n, data_o, exp_data);
                end
                ready_i = 1'b1;
                size_i = 7'd34;
                eop_i = (n == 14);
                @(posedge clk);
                n++;
                consumed += 34;
            end else begin
                ready_i = 1'b1;
                size_i = 7'd1;
                eop_i = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
            cyc++;
        end
        ready_i = 1'b0;
        eop_i = 1'b0;
        checks++;
        if (n != 15) begin failures++; $display("[TB] FAIL full_timeout: got %0d consumes expected 15", n); end
        checks++;
        if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL full_done: got %b expected 1", done_o); end
        checks++;
        if (fail_o !== 1'b0) begin failures++; $display("[TB] FAIL full_fail: got %b expected 0", fail_o); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (read_cnt[i] != 1) begin
                failures++; $display("[TB] FAIL full_reads[%0d]: got %0d expected 1", i, read_cnt[i]);
            end
        end
`ifdef AIDC_LITE_SPLIT_STAT_EN
        checks++;
        if (bits_o !== 10'd512) begin failures++; $display("[TB] FAIL full_bits: got %0d expected 512", bits_o); end
`else
        checks++;
        if (prefix_o !== 2'b01) begin failures++; $display("[TB] FAIL full_prefix: got %b expected 01", prefix_o); end
`endif
        @(negedge clk);
        checks++;
        if ({valid_o, rd_en_o, done_o} !== 3'b001) begin
            failures++; $display("[TB] FAIL full_hold: got valid=%b rd_en=%b done=%b expected 0 0 1", valid_o, rd_en_o, done_o);
        end
    endtask

    task automatic test_over_read();
        int n = 0;
        int consumed = 0;
        int cyc = 0;
        logic [511:0] tmp;
        logic [65:0]  exp_data;
        apply_reset();
        load_pattern();
        build_code();
        start_block();
        while (n < 11 && cyc < 2000) begin
            if (valid_o) begin
                ready_i = 1'b1;
                size_i = (n < 10) ? 7'd50 : 7'd20;
                eop_i = 1'b0;
                if (n == 10) begin
                    tmp = code << consumed;
                    exp_data = tmp[511 -: DATA_SIZE];
                    checks++;
                    if (data_o !== exp_data) begin
                        failures++; $display("[TB] FAIL over_tail_data: got %h expected %h", data_o, exp_data);
                    end
                    checks++;
                    if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL over_early_done: got %b expected 0", done_o); end
                end
                @(posedge clk);
                n++;
                consumed += (n <= 10) ? 50 : 20;
            end else begin
                ready_i = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            cyc++;
        end
        ready_i = 1'b0;
        checks++;
        if (n != 11) begin failures++; $display("[TB] FAIL over_timeout: got %0d consumes expected 11", n); end
        checks++;
        if ({done_o, fail_o} !== 2'b11) begin
            failures++; $display("[TB] FAIL over_status: got done=%b fail=%b expected 1 1", done_o, fail_o);
        end
    endtask

    task automatic test_missing_eop();
        int n = 0;
        int cyc = 0;
        apply_reset();
        load_pattern();
        start_block();
        while (n < 15 && cyc < 2000) begin
            if (valid_o) begin
                ready_i = 1'b1;
                size_i = 7'd34;
                eop_i = 1'b0;
                @(posedge clk);
                n++;
            end else begin
                ready_i = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            cyc++;
        end
        ready_i = 1'b0;
        checks++;
        if (n != 15) begin failures++; $display("[TB] FAIL noeop_timeout: got %0d consumes expected 15", n); end
        checks++;
        if ({done_o, valid_o} !== 2'b00) begin
            failures++; $display("[TB] FAIL noeop_drain: got done=%b valid=%b expected 0 0", done_o, valid_o);
        end
        @(negedge clk);
        checks++;
        if ({done_o, fail_o} !== 2'b11) begin
            failures++; $display("[TB] FAIL noeop_status: got done=%b fail=%b expected 1 1", done_o, fail_o);
        end
`ifdef AIDC_LITE_SPLIT_STAT_EN
        checks++;
        if (bits_o !== 10'd512) begin failures++; $display("[TB] FAIL noeop_bits: got %0d expected 512", bits_o); end
`endif
    endtask

    task automatic test_reset_mid_block();
        int cyc = 0;
        bit hit = 0;
        logic [65:0] exp_data;
        apply_reset();
        load_pattern();
        start_block();
        while (!hit && cyc < 200) begin
            if (valid_o) begin
                ready_i = 1'b1;
                size_i = 7'd34;
            end else begin
                ready_i = 1'b0;
            end
            eop_i = 1'b0;
            #1;
            if (rd_en_o && rd_addr_o == 3'd3) begin
                hit = 1;
                rst_n = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b1;
        ready_i = 1'b0;
        checks++;
        if (!hit) begin failures++; $display("[TB] FAIL mid_timeout: got no addr3 request expected one"); end
        @(negedge clk);
        checks++;
        if ({valid_o, rd_en_o, done_o, fail_o} !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL mid_idle: got valid=%b rd_en=%b done=%b fail=%b expected 0 0 1 0", valid_o, rd_en_o, done_o, fail_o);
        end
        checks++;
        if (prefix_o !== 2'b00) begin failures++; $display("[TB] FAIL mid_prefix_clr: got %b expected 00", prefix_o); end
        mem[0] = 64'hB2C4_6E8A_1357_9BDF;
        clear_reads();
        start_block();
        checks++;
        if ({rd_en_o, rd_addr_o} !== 4'b1_000) begin
            failures++; $display("[TB] FAIL mid_restart_addr0: got en=%b addr=%0d expected en=1 addr=0", rd_en_o, rd_addr_o);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_restart_valid: got %b expected 1", valid_o); end
        checks++;
        if (prefix_o !== 2'b10) begin failures++; $display("[TB] FAIL mid_restart_prefix: got %b expected 10", prefix_o); end
        exp_data = {mem[0][61:0], mem[1][63:60]};
        checks++;
        if (data_o !== exp_data) begin
            failures++; $display("[TB] FAIL mid_restart_data: got %h expected %h", data_o, exp_data);
        end
        checks++;
        if (read_cnt[0] != 1 || read_cnt[1] != 1) begin
            failures++; $display("[TB] FAIL mid_restart_reads: got %0d/%0d expected 1/1", read_cnt[0], read_cnt[1]);
        end
    endtask

    initial begin
        clear_reads();
        load_pattern();
        test_reset();
        test_start_latency();
        test_full_block();
        test_over_read();
        test_missing_eop();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
